// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared control-word type, bubble constant and MIPS encodings
package id_ex_stage_pkg;

    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic [3:0] mem_write;
        logic [1:0] mem_read_width;
        logic [3:0] alu_operation;
        logic [5:0] opcode;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    localparam logic [1:0] MRW_WORD = 2'd0;
    localparam logic [1:0] MRW_HALF = 2'd1;
    localparam logic [1:0] MRW_BYTE = 2'd2;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_ADDU = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_SUBU = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_XOR  = 4'd8,
        ALU_NOR  = 4'd9,
        ALU_LUI  = 4'hF
    } alu_op_t;

    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// rtl/id_ex_stage_hazard_detect.sv - combinational load-use hazard and stall detection
module hazard_detect #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      ex_valid,
    input  logic                      ex_MemtoReg,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_RegDst,
    input  logic                      id_Branch,
    input  logic [3:0]                id_MemWrite,
    input  logic                      flush,
    output logic                      hazard,
    output logic                      stall
);

    logic uses_rt;

    // rt is a true source for R-type, branches and stores; for I-type ALU ops it is the destination
    assign uses_rt = id_RegDst | id_Branch | (|id_MemWrite);

    assign hazard = ex_valid & ex_MemtoReg & (|ex_rt) &
                    ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));

    assign stall = hazard & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble, flush squash and debug counters
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_RegDst,
    input  logic                      id_Branch,
    input  logic                      id_MemtoReg,
    input  logic                      id_ALUSrc,
    input  logic                      id_RegWrite,
    input  logic [3:0]                id_MemWrite,
    input  logic [1:0]                id_memReadWidth,
    input  logic [3:0]                id_aluOperation,
    input  logic [5:0]                id_opcode,
    input  logic [DATA_WIDTH-1:0]     id_pcPlus4,
    input  logic [DATA_WIDTH-1:0]     id_readData1,
    input  logic [DATA_WIDTH-1:0]     id_readData2,
    input  logic [DATA_WIDTH-1:0]     id_immediate,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      flush,
    output logic                      ex_RegDst,
    output logic                      ex_Branch,
    output logic                      ex_MemtoReg,
    output logic                      ex_ALUSrc,
    output logic                      ex_RegWrite,
    output logic [3:0]                ex_MemWrite,
    output logic [1:0]                ex_memReadWidth,
    output logic [3:0]                ex_aluOperation,
    output logic [5:0]                ex_opcode,
    output logic [DATA_WIDTH-1:0]     ex_pcPlus4,
    output logic [DATA_WIDTH-1:0]     ex_readData1,
    output logic [DATA_WIDTH-1:0]     ex_readData2,
    output logic [DATA_WIDTH-1:0]     ex_immediate,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs,
    output logic [REG_ADDR_WIDTH-1:0] ex_rt,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      ex_valid,
    output logic                      stall,
    output logic [CNT_WIDTH-1:0]      stall_count,
    output logic [CNT_WIDTH-1:0]      flush_count
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  hazard;

    assign id_ctrl = '{
        reg_dst:        id_RegDst,
        branch:         id_Branch,
        mem_to_reg:     id_MemtoReg,
        alu_src:        id_ALUSrc,
        reg_write:      id_RegWrite,
        mem_write:      id_MemWrite,
        mem_read_width: id_memReadWidth,
        alu_operation:  id_aluOperation,
        opcode:         id_opcode
    };

    assign ex_RegDst       = ex_ctrl.reg_dst;
    assign ex_Branch       = ex_ctrl.branch;
    assign ex_MemtoReg     = ex_ctrl.mem_to_reg;
    assign ex_ALUSrc       = ex_ctrl.alu_src;
    assign ex_RegWrite     = ex_ctrl.reg_write;
    assign ex_MemWrite     = ex_ctrl.mem_write;
    assign ex_memReadWidth = ex_ctrl.mem_read_width;
    assign ex_aluOperation = ex_ctrl.alu_operation;
    assign ex_opcode       = ex_ctrl.opcode;

    hazard_detect #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_hazard_detect (
        .ex_valid    (ex_valid),
        .ex_MemtoReg (ex_ctrl.mem_to_reg),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_RegDst   (id_RegDst),
        .id_Branch   (id_Branch),
        .id_MemWrite (id_MemWrite),
        .flush       (flush),
        .hazard      (hazard),
        .stall       (stall)
    );

    // A bubble clears data and addresses too, so a squashed slot never aliases a real register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl      <= CTRL_BUBBLE;
            ex_pcPlus4   <= '0;
            ex_readData1 <= '0;
            ex_readData2 <= '0;
            ex_immediate <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_valid     <= 1'b0;
        end else if (flush || hazard) begin
            ex_ctrl      <= CTRL_BUBBLE;
            ex_pcPlus4   <= '0;
            ex_readData1 <= '0;
            ex_readData2 <= '0;
            ex_immediate <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_valid     <= 1'b0;
        end else begin
            ex_ctrl      <= id_ctrl;
            ex_pcPlus4   <= id_pcPlus4;
            ex_readData1 <= id_readData1;
            ex_readData2 <= id_readData2;
            ex_immediate <= id_immediate;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_rd        <= id_rd;
            ex_valid     <= 1'b1;
        end
    end

    // Flush has priority, so a squashed load-use pair counts only as a flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (flush) begin
            if (flush_count != '1) flush_count <= flush_count + 1'b1;
        end else if (hazard) begin
            if (stall_count != '1) stall_count <= stall_count + 1'b1;
        end
    end

endmodule
